// File: rtl/prbs_checker_if.sv
// Serial PRBS stream in, lock/error status and counters out.
// Stream input has no backpressure: the checker accepts every bit flagged by din_valid.
interface prbs_checker_if #(
    parameter int CNT_W = 16
);
    logic             clr;
    logic             din_valid;
    logic             din;
    logic             locked;
    logic             err;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] bit_count;

    modport master (
        output clr, din_valid, din,
        input  locked, err, err_count, bit_count
    );

    modport slave (
        input  clr, din_valid, din,
        output locked, err, err_count, bit_count
    );
endinterface

// File: rtl/prbs_checker.sv
// Self-synchronising checker for the 4-bit Fibonacci LFSR stream; status/counters update 1 cycle after each valid bit.
// No backpressure: every bit with din_valid is consumed; idle cycles are transparent.
module prbs_checker #(
    parameter int             WIDTH       = 4,
    parameter logic [WIDTH-1:0] TAPS      = 4'b1010,
    parameter int             LOCK_CNT    = 8,
    parameter int             UNLOCK_ERRS = 4,
    parameter int             CNT_W       = 16
) (
    input logic           clk,
    input logic           rst,
    prbs_checker_if.slave bus
);

    localparam int CLEAN_RUN = 16;
    localparam int FILL_W    = $clog2(WIDTH + 1);
    localparam int MATCH_W   = $clog2(LOCK_CNT + 1);
    localparam int MISS_W    = $clog2(UNLOCK_ERRS + 1);
    localparam int CLEAN_W   = $clog2(CLEAN_RUN + 1);

    localparam logic [FILL_W-1:0]  FILL_FULL  = FILL_W'(WIDTH);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
    localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(UNLOCK_ERRS - 1);
    localparam logic [CLEAN_W-1:0] CLEAN_LAST = CLEAN_W'(CLEAN_RUN - 1);

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [MISS_W-1:0]  miss_q, miss_d;
    logic [CLEAN_W-1:0] clean_q, clean_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;
    logic [CNT_W-1:0]   bit_count_q, bit_count_d;

    logic pred;
    logic mismatch;
    logic err_inc;
    logic bit_inc;

    assign pred     = ^(sh_q & TAPS);
    assign mismatch = bus.din != pred;

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        fill_d  = fill_q;
        match_d = match_q;
        miss_d  = miss_q;
        clean_d = clean_q;
        err_d   = 1'b0;
        err_inc = 1'b0;
        bit_inc = 1'b0;

        if (bus.din_valid) begin
            case (state_q)
                SEARCH: begin
                    sh_d = {sh_q[WIDTH-2:0], bus.din};
                    if (fill_q != FILL_FULL) begin
                        fill_d = fill_q + 1'b1;
                    end else if (sh_q == '0) begin
                        // All-zero shadow predicts zeros forever; never credit it toward lock.
                        match_d = '0;
                    end else if (mismatch) begin
                        match_d = '0;
                    end else if (match_q == MATCH_LAST) begin
                        state_d = LOCKED;
                        match_d = '0;
                        miss_d  = '0;
                        clean_d = '0;
                    end else begin
                        match_d = match_q + 1'b1;
                    end
                end

                LOCKED: begin
                    // Flywheel on the prediction so a channel error does not corrupt later predictions.
                    sh_d    = {sh_q[WIDTH-2:0], pred};
                    bit_inc = 1'b1;
                    if (mismatch) begin
                        err_d   = 1'b1;
                        err_inc = 1'b1;
                        clean_d = '0;
                        if (miss_q == MISS_LAST) begin
                            state_d = SEARCH;
                            fill_d  = '0;
                            match_d = '0;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_q + 1'b1;
                        end
                    end else if (clean_q == CLEAN_LAST) begin
                        clean_d = '0;
                        miss_d  = '0;
                    end else begin
                        clean_d = clean_q + 1'b1;
                    end
                end

                default: state_d = SEARCH;
            endcase
        end
    end

    always_comb begin
        err_count_d = err_count_q;
        bit_count_d = bit_count_q;
        if (bus.clr) begin
            err_count_d = '0;
            bit_count_d = '0;
        end else begin
            if (err_inc && (err_count_q != '1)) err_count_d = err_count_q + 1'b1;
            if (bit_inc && (bit_count_q != '1)) bit_count_d = bit_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SEARCH;
            sh_q        <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            miss_q      <= '0;
            clean_q     <= '0;
            err_q       <= 1'b0;
            err_count_q <= '0;
            bit_count_q <= '0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            clean_q     <= clean_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
            bit_count_q <= bit_count_d;
        end
    end

    assign bus.locked    = (state_q == LOCKED);
    assign bus.err       = err_q;
    assign bus.err_count = err_count_q;
    assign bus.bit_count = bit_count_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: lock, single error, unlock/relock, garbage rejection, gaps, clr, async reset.
module tb_prbs_checker;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    prbs_checker_if #(.CNT_W(16)) bus ();

    prbs_checker #(
        .WIDTH(4), .TAPS(4'b1010), .LOCK_CNT(8), .UNLOCK_ERRS(4), .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Generator output sequence 0,1,1,1,1,0 (index 0 sent first).
    logic [5:0] pat_bits = 6'b011110;
    int idx      = 0;
    int checks   = 0;
    int errors   = 0;
    int err_hits = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic b, input logic c);
        @(negedge clk);
        bus.din_valid = v;
        bus.din       = b;
        bus.clr       = c;
        @(posedge clk);
        #1;
        if (bus.err) err_hits++;
        bus.din_valid = 1'b0;
        bus.clr       = 1'b0;
    endtask

    task automatic clean(input int n);
        repeat (n) begin
            step(1'b1, pat_bits[idx], 1'b0);
            idx = (idx + 1) % 6;
        end
    endtask

    task automatic flip(input logic c);
        step(1'b1, ~pat_bits[idx], c);
        idx = (idx + 1) % 6;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.clr       = 1'b0;
        bus.din_valid = 1'b0;
        bus.din       = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_locked", bus.locked, 0);
        check("reset_err", bus.err, 0);
        check("reset_err_count", bus.err_count, 0);
        check("reset_bit_count", bus.bit_count, 0);
        rst = 1'b0;

        // Lock: 4 fill bits + 8 matching predictions.
        clean(11);
        check("lock_not_yet", bus.locked, 0);
        clean(1);
        check("lock_after_12", bus.locked, 1);
        check("lock_bit_count_zero", bus.bit_count, 0);
        clean(60);
        check("clean60_bit_count", bus.bit_count, 60);
        check("clean60_err_count", bus.err_count, 0);
        check("clean60_no_err", err_hits, 0);

        // Single error: one pulse, no multiplication.
        flip(1'b0);
        check("single_err_pulse", bus.err, 1);
        check("single_err_count", bus.err_count, 1);
        check("single_locked", bus.locked, 1);
        clean(1);
        check("single_err_drop", bus.err, 0);
        clean(15);
        check("single_no_mult", err_hits, 1);
        check("single_err_count_after", bus.err_count, 1);

        // Miss count was cleared by the 16 clean bits, so 3 more errors keep lock.
        flip(1'b0); clean(2); flip(1'b0); clean(2); flip(1'b0);
        check("three_errs_locked", bus.locked, 1);
        check("three_errs_count", bus.err_count, 4);
        check("three_errs_bits", bus.bit_count, 84);
        clean(20);
        check("bits_before_clr", bus.bit_count, 104);

        // clr coinciding with an error: counters clear, err still pulses.
        flip(1'b1);
        check("clr_err_pulse", bus.err, 1);
        check("clr_err_count", bus.err_count, 0);
        check("clr_bit_count", bus.bit_count, 0);
        check("clr_locked", bus.locked, 1);
        clean(20);
        check("post_clr_bits", bus.bit_count, 20);

        // Unlock: 4 errors spaced 3 apart.
        flip(1'b0); clean(2); flip(1'b0); clean(2); flip(1'b0); clean(2);
        check("unlock_before_4th", bus.locked, 1);
        flip(1'b0);
        check("unlock_4th_err", bus.err, 1);
        check("unlock_err_count", bus.err_count, 4);
        check("unlock_locked", bus.locked, 0);
        clean(11);
        check("relock_not_yet", bus.locked, 0);
        clean(1);
        check("relock_after_12", bus.locked, 1);
        check("relock_bit_count", bus.bit_count, 30);
        check("relock_err_hits", err_hits, 9);

        // Async reset between edges while locked with nonzero counts.
        flip(1'b0);
        check("pre_arst_err_count", bus.err_count, 5);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_locked", bus.locked, 0);
        check("arst_err_count", bus.err_count, 0);
        check("arst_bit_count", bus.bit_count, 0);
        check("arst_err", bus.err, 0);
        @(negedge clk);
        rst = 1'b0;

        // All-zero stream must not lock.
        repeat (40) step(1'b1, 1'b0, 1'b0);
        check("zeros_no_lock", bus.locked, 0);
        // Alternating pattern must not lock.
        for (int i = 0; i < 40; i++) step(1'b1, i[0] ? 1'b0 : 1'b1, 1'b0);
        check("alt_no_lock", bus.locked, 0);
        check("garbage_no_err", err_hits, 10);

        // Valid gaps: 1,0,0 pattern, idle din driven with noise.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            clean(1);
            step(1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
        check("gap_not_yet", bus.locked, 0);
        clean(1);
        check("gap_locked", bus.locked, 1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, ~pat_bits[idx], 1'b0);
            clean(1);
            step(1'b0, pat_bits[idx], 1'b0);
        end
        check("gap_bit_count", bus.bit_count, 10);
        check("gap_err_count", bus.err_count, 0);
        check("gap_no_err", err_hits, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Receive-side companion to the team's 4-bit Fibonacci feedback shift register generator. That generator uses seed 4'b1110, shifts left each cycle, and inserts new bit = sr[3]^sr[1] at the LSB.
- This block consumes that serial bit stream, self-synchronises to it, flags bit errors and counts them.
- Sits at the far end of a serial test link or loopback path. It is the pass/fail monitor for the LFSR pattern source.

Parameters:
- WIDTH, 4, LFSR length in bits.
- TAPS, 4'b1010, mask of shadow-register bits XORed to form the predicted bit (bit3 ^ bit1).
- LOCK_CNT, 8, consecutive correct predictions in SEARCH required to declare lock.
- UNLOCK_ERRS, 4, errors in LOCKED, without an intervening 16-bit clean run, that force return to SEARCH.
- CNT_W, 16, width of err_count and bit_count.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear of err_count and bit_count only; lock state unaffected.
- din_valid  input  1  din carries a stream bit this cycle.
- din  input  1  received serial bit (the generator's inserted feedback bit).
- locked  output  1  checker is synchronised to the stream.
- err  output  1  one-cycle pulse: the previous valid bit mismatched the prediction while LOCKED.
- err_count  output  CNT_W  saturating count of errors since reset/clr.
- bit_count  output  CNT_W  saturating count of valid bits checked while LOCKED.

Behaviour:
- Reset (async): state=SEARCH, shadow=0, fill=0, match_cnt=0, miss_cnt=0, clean_cnt=0. Outputs locked=0, err=0, err_count=0, bit_count=0.
- Shadow register sh[WIDTH-1:0] mirrors the generator. On update: sh <= {sh[WIDTH-2:0], x}.
- Predicted bit p = ^(sh & TAPS).
- Cycles with din_valid=0 change nothing except err, which returns to 0.
- SEARCH:
  - Every valid bit shifts din into sh.
  - fill counts 0..WIDTH and saturates at WIDTH. No comparison occurs while fill<WIDTH.
  - Once fill==WIDTH and sh!=0: din==p increments match_cnt; a mismatch clears match_cnt to 0.
  - When sh==0, match_cnt is held at 0. This prevents locking onto the all-zero lock-up stream.
  - When the valid bit that makes match_cnt reach LOCK_CNT arrives: next state=LOCKED, locked=1 from the following cycle, miss_cnt=0, clean_cnt=0.
  - err is never asserted in SEARCH, and the counters do not move.
- LOCKED:
  - Every valid bit shifts p, not din, into sh. This makes the block flywheel, so a single channel error is not multiplied.
  - bit_count increments on every valid bit.
  - Mismatch (din!=p): err=1 next cycle, err_count+1, miss_cnt+1, clean_cnt=0.
  - Match: clean_cnt+1. When clean_cnt reaches 16, miss_cnt=0 and clean_cnt=0.
  - When the mismatch that makes miss_cnt reach UNLOCK_ERRS arrives, it is still counted and pulses err. The next state is then SEARCH with locked=0, fill=0, match_cnt=0.
- Latency: err and the counters update on the clock edge after the sampled valid bit. err is registered and high for exactly one cycle per error.
- Counters saturate at all-ones and do not wrap.
- clr:
  - clr in the same cycle as a counted event: clr wins, so the counter becomes 0.
  - clr does not suppress err.
- rst mid-stream: immediate return to reset values; re-lock requires WIDTH + LOCK_CNT valid bits.
- din_valid gaps of any length are transparent; the sequence continues on the next valid bit.

Test Plan:
- Lock: after rst, feed the clean period-6 stream 0,1,1,1,1,0 repeated with din_valid=1 continuously. locked rises the cycle after bit 12 (WIDTH 4 + LOCK_CNT 8). err stays 0. After 60 more bits, bit_count=60 and err_count=0.
- Single error: while locked, invert one bit (expected 1, send 0). err pulses for exactly 1 cycle, err_count=1, locked stays 1. No further errors occur (no multiplication), and after 16 clean bits miss_cnt is back to 0.
- Unlock: while locked, invert 4 bits spaced 3 apart. err_count=4 and locked falls after the 4th error. Resuming the clean stream re-locks after 12 valid bits.
- All-zero and garbage rejection:
  - Feed 40 zeros: locked stays 0.
  - Feed the alternating pattern 1,0,1,0,...: locked stays 0.
- valid gaps and clr:
  - Clean stream with din_valid toggling 1,0,0,1,...: lock is still achieved and no err.
  - Assert clr for 1 cycle while locked: err_count=0 and bit_count=0 next cycle, locked unchanged.
- Async reset mid-lock: assert rst between clock edges. locked=0 and all counts=0 immediately, without waiting for a clock edge.
